// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial sequence detector.
// Holds the FSM state encoding and the fill-counter width helper.
package seq_det_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } seqState_e;

   localparam int       DefPatLen  = 4;
   localparam logic [3:0] DefPattern = 4'b1011;
   localparam int       DefCntW    = 8;

   // Fill counter must represent 0..patLen inclusive.
   function automatic int fillWidth(input int patLen);
      return $clog2(patLen + 1);
   endfunction

endpackage

// File: rtl/serial_seq_detector_if.sv
// Bus between the upstream serial bit stage and the sequence detector.
// master drives data/valid/clear, slave returns match results.
interface serial_seq_detector_if import seq_det_pkg::*; #(
   parameter int CNT_W = DefCntW
);

   logic             din;
   logic             din_valid;
   logic             clr;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;

   modport master (
      output din, din_valid, clr,
      input  match, match_cnt, cnt_sat
   );

   modport slave (
      input  din, din_valid, clr,
      output match, match_cnt, cnt_sat
   );

endinterface

// File: rtl/seq_match_counter.sv
// Saturating detection counter with synchronous clear; sat_o is registered
// alongside the count so it is high exactly while the count is all-ones.
module seq_match_counter import seq_det_pkg::*; #(
   parameter int CNT_W = DefCntW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q;

   // Clear wins over increment; the count holds at its maximum instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= (cnt_d == CntMax);
      end
   end

   assign cnt_o = cnt_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/serial_seq_detector.sv
// Detects PATTERN in the stream of valid serial bits and counts detections.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; default is non-overlapping.
module serial_seq_detector import seq_det_pkg::*; #(
   parameter int               PAT_LEN = DefPatLen,
   parameter logic [PAT_LEN-1:0] PATTERN = DefPattern,
   parameter int               CNT_W   = DefCntW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_seq_detector_if.slave bus
);

   localparam int                FillW    = fillWidth(PAT_LEN);
   localparam logic [FillW-1:0]  FillFull = FillW'(PAT_LEN);
   localparam logic [FillW-1:0]  FillLast = FillW'(PAT_LEN - 1);

`ifdef SEQ_DET_OVERLAP_EN
   localparam bit OverlapEn = 1'b1;
`else
   localparam bit OverlapEn = 1'b0;
`endif

   if (PAT_LEN < 2 || PAT_LEN > 16) begin : gBadPatLen
      $error("serial_seq_detector: PAT_LEN must be 2..16");
   end
   if (CNT_W < 1 || CNT_W > 16) begin : gBadCntW
      $error("serial_seq_detector: CNT_W must be 1..16");
   end

   logic [PAT_LEN-1:0] hist_q;
   logic [PAT_LEN-1:0] window;
   logic [FillW-1:0]   fill_q;
   seqState_e          state_q;
   logic               match_q;
   logic               hit;
   logic               countInc;
   logic               unusedHistMsb;

   // The oldest history bit falls out of the window as the new bit arrives.
   assign window        = {hist_q[PAT_LEN-2:0], bus.din};
   assign unusedHistMsb = hist_q[PAT_LEN-1];

   assign hit      = bus.din_valid && (window == PATTERN) &&
                     ((state_q == ARMED) || (fill_q == FillLast));
   assign countInc = hit && !bus.clr;

   // History, fill count and FSM; clear overrides both valid data and a hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q  <= '0;
         fill_q  <= '0;
         state_q <= FILL;
         match_q <= 1'b0;
      end else if (bus.clr) begin
         hist_q  <= '0;
         fill_q  <= '0;
         state_q <= FILL;
         match_q <= 1'b0;
      end else begin
         match_q <= hit;
         if (bus.din_valid) begin
            if (hit && !OverlapEn) begin
               hist_q  <= '0;
               fill_q  <= '0;
               state_q <= FILL;
            end else begin
               hist_q <= window;
               if (fill_q != FillFull) begin
                  fill_q <= fill_q + 1'b1;
               end
               if (fill_q == FillLast) begin
                  state_q <= ARMED;
               end
            end
         end
      end
   end

   seq_match_counter #(
      .CNT_W (CNT_W)
   ) uCounter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (countInc),
      .clr_i (bus.clr),
      .cnt_o (bus.match_cnt),
      .sat_o (bus.cnt_sat)
   );

   assign bus.match = match_q;

endmodule
